sync_manager_nbuf: RTL

//  Parametrised N-buffer frame manager between an S2MM frame writer and a frame reader (PS/DMA).

---
 rtl/sync_manager_nbuf_pkg.sv | 37 +++
 rtl/sync_manager_nbuf_index_fifo.sv | 84 ++++++++
 rtl/sync_manager_nbuf.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sync_manager_nbuf_pkg.sv
// Shared types, widths and helpers for the N-buffer frame manager.
package sync_manager_nbuf_pkg;

   typedef enum logic {
      ModeLatest = 1'b0,
      ModeQueue  = 1'b1
   } sm_mode_e;

   typedef enum logic {
      StRun,
      StStall
   } wr_state_e;

   localparam int unsigned ResetReadIdx  = 0;
   localparam int unsigned ResetWriteIdx = 1;

   localparam int unsigned LogLenWidth = 5;
   localparam int unsigned LevelWidth  = 4;
   localparam int unsigned DropWidth   = 16;

   // Ceiling log2, never below 1 so it can size a vector.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   function automatic logic [LogLenWidth-1:0] clamp_log(input logic [LogLenWidth-1:0] l,
                                                        input int unsigned max_log);
      if (32'(l) > max_log) return LogLenWidth'(max_log);
      return l;
   endfunction

endpackage

// File: rtl/sync_manager_nbuf_index_fifo.sv
// Circular FIFO of buffer indices: the ready queue of completed frames.
module sync_manager_nbuf_index_fifo
   import sync_manager_nbuf_pkg::*;
#(
   parameter int unsigned Depth  = 2,
   parameter int unsigned NumIdx = 4,
   parameter int unsigned IdxW   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [IdxW-1:0]       push_idx_i,
   input  logic                  pop_oldest_i,
   input  logic                  pop_newest_flush_i,
   output logic [LevelWidth-1:0] level_o,
   output logic [NumIdx-1:0]     bitmap_o,
   output logic [IdxW-1:0]       head_o,
   output logic [IdxW-1:0]       tail_o
);

   localparam int unsigned PtrW = clog2(Depth);

   logic [IdxW-1:0]       mem_q [Depth];
   logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [LevelWidth-1:0] level_q, level_d;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
   endfunction

   function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
      return (p == '0) ? PtrW'(Depth - 1) : p - PtrW'(1);
   endfunction

   assign level_o = level_q;
   assign head_o  = mem_q[head_q];
   assign tail_o  = mem_q[ptr_dec(tail_q)];

   // Mark every index currently held in the queue.
   always_comb begin
      bitmap_o = '0;
      for (int i = 0; i < int'(Depth); i++) begin
         int slot;
         slot = int'(head_q) + i;
         if (slot >= int'(Depth)) slot = slot - int'(Depth);
         if (i < int'(level_q)) bitmap_o[mem_q[PtrW'(slot)]] = 1'b1;
      end
   end

   // Pointer/level update; a flush empties the queue and overrides push/pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      if (pop_newest_flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         level_d = '0;
      end else begin
         if (push_i)       tail_d = ptr_inc(tail_q);
         if (pop_oldest_i) head_d = ptr_inc(head_q);
         level_d = level_q + LevelWidth'(push_i) - LevelWidth'(pop_oldest_i);
      end
   end

   // Pointer and level registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
      end
   end

   // Entry storage; push into a full queue overwrites the slot being popped.
   always_ff @(posedge clk_i) begin
      if (push_i && !pop_newest_flush_i) mem_q[tail_q] <= push_idx_i;
   end

endmodule

// File: rtl/sync_manager_nbuf.sv
// N-buffer frame manager: writer allocation, ready queue publish, reader hand-off.
module sync_manager_nbuf
   import sync_manager_nbuf_pkg::*;
#(
   parameter int unsigned MM_ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BUFFER_COUNT   = 4,
   parameter int unsigned MAX_LOG_LENGTH = 22
) (
   input  logic                     SYS_aclk,
   input  logic                     SYS_reset,
   input  logic                     SM_mode,
   input  logic                     SM_request,
   input  logic [LogLenWidth-1:0]   SM_log_length,
   input  logic [MM_ADDR_WIDTH-1:0] SM_base_address,
   input  logic                     SM_write_beat,
   output logic                     SM_write_ready,
   output logic [MM_ADDR_WIDTH-1:0] SM_write_buffer,
   output logic [MM_ADDR_WIDTH-1:0] SM_read_buffer,
   output logic                     SM_read_valid,
   output logic [LevelWidth-1:0]    SM_queue_level,
   output logic [DropWidth-1:0]     SM_drop_count,
   output logic                     SM_overflow
);

   localparam int unsigned QDepth = BUFFER_COUNT - 2;
   localparam int unsigned IdxW   = clog2(BUFFER_COUNT);
   localparam int unsigned CntW   = MAX_LOG_LENGTH;
   localparam int unsigned Bpb    = DATA_WIDTH / 8;

   wr_state_e             state_q, state_d;
   logic                  write_ready_q, write_ready_d;
   logic [IdxW-1:0]       read_q, read_d, write_q, write_d;
   logic [CntW-1:0]       write_count_q, write_count_d;
   logic [LogLenWidth-1:0] log_len_q, log_len_d;
   logic                  valid_q, valid_d, overflow_q, overflow_d, req_q;
   logic [DropWidth-1:0]  drop_q, drop_d;

   logic [LevelWidth-1:0]   fifo_level, level_pub, drops;
   logic [BUFFER_COUNT-1:0] fifo_bitmap, free_vec;
   logic [IdxW-1:0]         fifo_head, fifo_tail, newest, oldest, alloc;
   logic [CntW-1:0]         len_m1;
   logic [DropWidth:0]      drop_sum;
   logic frame_end, pub, q_full, q_empty, req_edge, mode_queue, req_pop_space;
   logic push, pub_pop, req_act, pop_oldest, flush;

   function automatic logic [BUFFER_COUNT-1:0] onehot(input logic [IdxW-1:0] idx);
      return BUFFER_COUNT'(1) << idx;
   endfunction

   sync_manager_nbuf_index_fifo #(
      .Depth (QDepth),
      .NumIdx(BUFFER_COUNT),
      .IdxW  (IdxW)
   ) u_fifo (
      .clk_i             (SYS_aclk),
      .rst_i             (SYS_reset),
      .push_i            (push),
      .push_idx_i        (write_q),
      .pop_oldest_i      (pop_oldest),
      .pop_newest_flush_i(flush),
      .level_o           (fifo_level),
      .bitmap_o          (fifo_bitmap),
      .head_o            (fifo_head),
      .tail_o            (fifo_tail)
   );

   assign SM_write_buffer = SM_base_address +
      (((MM_ADDR_WIDTH'(write_q) << log_len_q) + MM_ADDR_WIDTH'(write_count_q)) *
       MM_ADDR_WIDTH'(Bpb));
   assign SM_read_buffer  = SM_base_address +
      ((MM_ADDR_WIDTH'(read_q) << log_len_q) * MM_ADDR_WIDTH'(Bpb));
   assign SM_write_ready  = write_ready_q;
   assign SM_read_valid   = valid_q;
   assign SM_queue_level  = fifo_level;
   assign SM_drop_count   = drop_q;
   assign SM_overflow     = overflow_q;

   // Publish/request arbitration, free-index selection and next-state.
   always_comb begin
      len_m1     = ~({CntW{1'b1}} << log_len_q);
      frame_end  = write_ready_q && SM_write_beat && (write_count_q == len_m1);
      pub        = frame_end || (state_q == StStall);
      q_full     = (fifo_level == LevelWidth'(QDepth));
      q_empty    = (fifo_level == '0);
      req_edge   = SM_request && !req_q;
      mode_queue = (SM_mode == ModeQueue);
      // A queue-mode pop on the same edge makes room for a blocked publish.
      req_pop_space = req_edge && mode_queue && !q_empty;
      push       = pub && (!q_full || !mode_queue || req_pop_space);
      pub_pop    = push && q_full && !mode_queue;
      // Publish happens first, so the request sees the just-pushed entry.
      level_pub  = fifo_level + LevelWidth'(push) - LevelWidth'(pub_pop);
      req_act    = req_edge && (level_pub != '0);
      pop_oldest = pub_pop || (req_act && mode_queue);
      flush      = req_act && !mode_queue;
      newest     = push ? write_q : fifo_tail;
      oldest     = q_empty ? write_q : fifo_head;

      read_d = read_q;
      if (req_act) read_d = mode_queue ? oldest : newest;

      drops = '0;
      if (pub_pop) drops = LevelWidth'(1);
      if (flush)   drops = drops + level_pub - LevelWidth'(1);

      // Free set after this edge's releases; lowest index wins.
      free_vec = ~(onehot(write_q) | onehot(read_q) | fifo_bitmap);
      if (pub_pop) free_vec = free_vec | onehot(fifo_head);
      if (req_act) free_vec = free_vec | onehot(read_q);
      if (flush)   free_vec = free_vec | fifo_bitmap;
      free_vec = free_vec & ~(onehot(read_d) | onehot(write_q));
      alloc = IdxW'(ResetWriteIdx);
      for (int i = int'(BUFFER_COUNT) - 1; i >= 0; i--) begin
         if (free_vec[i]) alloc = IdxW'(i);
      end

      write_d       = write_q;
      state_d       = state_q;
      write_ready_d = write_ready_q;
      log_len_d     = log_len_q;
      if (push) begin
         write_d       = alloc;
         state_d       = StRun;
         write_ready_d = 1'b1;
         log_len_d     = clamp_log(SM_log_length, MAX_LOG_LENGTH);
      end else if (pub) begin
         state_d       = StStall;
         write_ready_d = 1'b0;
      end

      write_count_d = write_count_q;
      if (frame_end)                           write_count_d = '0;
      else if (SM_write_beat && write_ready_q) write_count_d = write_count_q + CntW'(1);

      valid_d    = valid_q | req_act;
      drop_sum   = {1'b0, drop_q} + (DropWidth + 1)'(drops);
      drop_d     = drop_sum[DropWidth] ? '1 : drop_sum[DropWidth-1:0];
      overflow_d = SM_write_beat && !write_ready_q;
   end

   // Writer FSM, role indices, counters and registered outputs.
   always_ff @(posedge SYS_aclk) begin
      if (SYS_reset) begin
         state_q       <= StRun;
         write_ready_q <= 1'b1;
         read_q        <= IdxW'(ResetReadIdx);
         write_q       <= IdxW'(ResetWriteIdx);
         write_count_q <= '0;
         log_len_q     <= clamp_log(SM_log_length, MAX_LOG_LENGTH);
         valid_q       <= 1'b0;
         drop_q        <= '0;
         overflow_q    <= 1'b0;
         req_q         <= SM_request;
      end else begin
         state_q       <= state_d;
         write_ready_q <= write_ready_d;
         read_q        <= read_d;
         write_q       <= write_d;
         write_count_q <= write_count_d;
         log_len_q     <= log_len_d;
         valid_q       <= valid_d;
         drop_q        <= drop_d;
         overflow_q    <= overflow_d;
         req_q         <= SM_request;
      end
   end

endmodule
